blink_select_ctrl: RTL and testbench
====================================

# blink_select_ctrl

Selection controller for the four-rate LED blink demonstration. It takes the two raw board switches and debounces them. It then drives the 2-bit select of the 4-to-1 blinker mux, replacing the direct switch-to-select wiring. Switch 1 steps through the four blink rates on release. Switch 2 toggles an auto-scan mode that steps the rate on its own after a fixed period.

## Interface
- DEBOUNCE_LIMIT, 250000: consecutive synchronized-mismatch cycles needed to accept a switch change (10 ms at 25 MHz); must be >= 2.
- AUTO_PERIOD, 75000000: cycles between automatic select steps in auto-scan mode (3 s at 25 MHz); must be >= 2.
- i_Clk  input  1  system clock, all logic on rising edge.
- i_Rst_L  input  1  asynchronous, active-low reset.
- i_Switch_1  input  1  raw switch, active-high; release steps select forward.
- i_Switch_2  input  1  raw switch, active-high; release toggles auto-scan (see Configuration).
- o_Sel  output  2  mux select; bit 0 drives sel1, bit 1 drives sel2.
- o_Auto  output  1  high while auto-scan mode is active.
- o_Change  output  1  one-cycle pulse on the cycle o_Sel takes a new value.

## Operation
- Per switch: 2-flop synchronizer, then debounce counter ($clog2(DEBOUNCE_LIMIT) bits) and debounced state r_Deb.
- Counter behaviour: while synced value != r_Deb, counter increments. Counter clears whenever they match.
- Debounce update: when counter == DEBOUNCE_LIMIT-1 and still mismatched, r_Deb takes the synced value at that edge and the counter clears.
- Release event: r_Deb transitions 1->0, detected against a registered copy of r_Deb. This produces a one-cycle internal pulse. Press edges are ignored.
- Switch 1 release: o_Sel <= o_Sel + 1, mod 4 (3 wraps to 0). Also clears the auto period counter.
- Auto-scan: period counter ($clog2(AUTO_PERIOD) bits) runs only while o_Auto = 1. At AUTO_PERIOD-1 it wraps to 0, and on that edge o_Sel increments mod 4.
- Entering auto mode clears the period counter. Leaving it clears and holds the counter; o_Sel keeps its current value.
- Simultaneous switch 1 release and period tick in the same cycle: single increment only, and the counter clears.
- Simultaneous switch 1 and switch 2 releases: both take effect in the same cycle (step plus mode toggle). On a mode entry, the counter clears.
- o_Change is high exactly on cycles after an edge where o_Sel changed value; it is registered and not derived from the events.
- State held: o_Sel, o_Auto, two debounce channels, the period counter. No other FSM.

## Timing
- Reset (i_Rst_L = 0, asynchronous, at any time including mid-debounce or mid-period) forces the following immediately:
  - o_Sel = 0, o_Auto = 0, o_Change = 0.
  - Synchronizers, r_Deb and its registered copy = 0.
  - All counters = 0.
- Release after reset is synchronous to i_Clk. A switch held high through reset release registers as a new press after debounce. It causes no event until released.
- Latency from raw release (stable low): 2 sync cycles, DEBOUNCE_LIMIT cycles to update r_Deb, and 1 cycle to update o_Sel. o_Sel changes DEBOUNCE_LIMIT+3 edges after the first sampling edge. o_Change is high during the following cycle.
- Glitches shorter than DEBOUNCE_LIMIT synced cycles produce no event.
- Auto step spacing: exactly AUTO_PERIOD cycles between o_Sel changes with no manual input. The first step comes AUTO_PERIOD cycles after o_Auto rises.

## Configuration
- Macro BLINK_SELECT_AUTO_SCAN_EN.
- Defined: auto-scan logic and period counter are present, and switch 2 release toggles o_Auto as above.
- Undefined:
  - No period counter is built, and o_Auto is tied to 0.
  - Switch 2 release steps o_Sel backward (o_Sel - 1 mod 4, 0 wraps to 3), with the same o_Change behaviour.
  - Simultaneous switch 1 and switch 2 releases cancel: no change and no o_Change pulse.

## Test plan
- Setup: DEBOUNCE_LIMIT=4, AUTO_PERIOD=16 for all tests.
- Reset, then 4 clean switch 1 press/release cycles: o_Sel sequence 1,2,3,0. Each change lands 7 edges after the release sample, with one o_Change pulse per step.
- Switch 1 release pulses of 1-3 synced cycles (bounce): o_Sel stays 0 and o_Change never asserts. A following 10-cycle-stable release steps o_Sel to 1.
- Macro defined, switch 2 released: o_Auto=1. o_Sel steps every 16 cycles, 0 to 1 to 2. A switch 1 release 5 cycles after a step increments once and restarts the 16-cycle spacing. A second switch 2 release sets o_Auto=0 and o_Sel freezes.
- Macro defined, auto on, switch 1 release event coincident with a period tick: o_Sel increments by exactly 1.
- Macro undefined, o_Sel=0, switch 2 release: o_Sel=3. Simultaneous switch 1 and switch 2 releases: o_Sel unchanged, o_Change stays 0.
- Assert i_Rst_L low mid-debounce and mid-period with o_Sel=2, o_Auto=1: all outputs 0 immediately, before the next clock edge. No spurious step after reset release.

Source files
------------

// File: rtl/blink_select_ctrl_if.sv
// Switch/select bundle between the board switches, the select controller and the blinker mux.
// The master side drives the raw switches; the slave side (the controller) drives the select outputs.
interface blink_select_ctrl_if;
    logic       i_Switch_1;
    logic       i_Switch_2;
    logic [1:0] o_Sel;
    logic       o_Auto;
    logic       o_Change;

    modport master (
        output i_Switch_1,
        output i_Switch_2,
        input  o_Sel,
        input  o_Auto,
        input  o_Change
    );

    modport slave (
        input  i_Switch_1,
        input  i_Switch_2,
        output o_Sel,
        output o_Auto,
        output o_Change
    );
endinterface

// File: rtl/blink_select_ctrl.sv
// Debounced two-switch select controller for the four-rate blinker mux.
// Define BLINK_SELECT_AUTO_SCAN_EN for switch-2 auto-scan; otherwise switch 2 steps the select backward.
module blink_select_ctrl #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int AUTO_PERIOD    = 75000000
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    blink_select_ctrl_if.slave bus
);
    localparam int            DW      = $clog2(DEBOUNCE_LIMIT);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_LIMIT - 1);

    if (DEBOUNCE_LIMIT < 2 || AUTO_PERIOD < 2) begin : g_param_check
        $error("blink_select_ctrl: DEBOUNCE_LIMIT and AUTO_PERIOD must be >= 2");
    end

    logic [1:0]    raw;
    logic [1:0]    sync_p0;
    logic [1:0]    sync_p1;
    logic [1:0]    deb_p2;
    logic [1:0]    deb_p3;
    logic [1:0]    rel;
    logic [DW-1:0] dcnt_p2 [2];
    logic [1:0]    sel_q;
    logic [1:0]    sel_next;
    logic          chg_q;

    assign raw = {bus.i_Switch_2, bus.i_Switch_1};

    // Stage p0/p1: synchronizer; stage p2: debounced level; stage p3: copy for edge detect
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            deb_p2  <= '0;
            deb_p3  <= '0;
            for (int i = 0; i < 2; i++) begin
                dcnt_p2[i] <= '0;
            end
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            deb_p3  <= deb_p2;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] != deb_p2[i]) begin
                    if (dcnt_p2[i] == DEB_MAX) begin
                        deb_p2[i]  <= sync_p1[i];
                        dcnt_p2[i] <= '0;
                    end else begin
                        dcnt_p2[i] <= dcnt_p2[i] + 1'b1;
                    end
                end else begin
                    dcnt_p2[i] <= '0;
                end
            end
        end
    end

    // Release only: debounced level fell since the previous cycle
    assign rel = deb_p3 & ~deb_p2;

`ifdef BLINK_SELECT_AUTO_SCAN_EN
    localparam int            PW      = $clog2(AUTO_PERIOD);
    localparam logic [PW-1:0] PER_MAX = PW'(AUTO_PERIOD - 1);

    logic [PW-1:0] pcnt;
    logic          auto_q;
    logic          tick;

    assign tick = auto_q && (pcnt == PER_MAX);

    // A manual step coinciding with a period tick still advances only once
    always_comb begin
        sel_next = sel_q;
        if (rel[0] || tick) begin
            sel_next = sel_q + 2'd1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            auto_q <= 1'b0;
            pcnt   <= '0;
        end else begin
            if (rel[1]) begin
                auto_q <= ~auto_q;
            end
            if (!auto_q || rel[1] || rel[0] || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    assign bus.o_Auto = auto_q;
`else
    // Both releases together cancel out
    always_comb begin
        sel_next = sel_q;
        case (rel)
            2'b01:   sel_next = sel_q + 2'd1;
            2'b10:   sel_next = sel_q - 2'd1;
            default: sel_next = sel_q;
        endcase
    end

    assign bus.o_Auto = 1'b0;
`endif

    // Output stage: select and its change flag
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sel_q <= 2'd0;
            chg_q <= 1'b0;
        end else begin
            sel_q <= sel_next;
            chg_q <= (sel_next != sel_q);
        end
    end

    assign bus.o_Sel    = sel_q;
    assign bus.o_Change = chg_q;
endmodule

// File: tb/tb_blink_select_ctrl.sv
// Self-checking bench for blink_select_ctrl: directed scenarios plus randomized switch activity
// compared against a history-based behavioural model of debounce, stepping and auto-scan.
module tb_blink_select_ctrl;
    localparam int DL = 4;
    localparam int AP = 16;

    logic i_Clk   = 1'b0;
    logic i_Rst_L = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    blink_select_ctrl_if bus ();

    blink_select_ctrl #(
        .DEBOUNCE_LIMIT(DL),
        .AUTO_PERIOD   (AP)
    ) dut (
        .i_Clk  (i_Clk),
        .i_Rst_L(i_Rst_L),
        .bus    (bus)
    );

    always #5 i_Clk = ~i_Clk;

    // Reference model: raw samples per edge, a switch's level flips once its last DL
    // synchronized samples all disagree with it; a 1->0 flip applies to the select one edge later.
    int edge_n;
    int restart_edge;
    int m_sel;
    bit m_auto;
    bit m_chg;
    bit m_deb [2];
    bit m_rel [2];
    bit hist0 [$];
    bit hist1 [$];

    function automatic void model_reset();
        edge_n       = 0;
        restart_edge = 0;
        m_sel        = 0;
        m_auto       = 1'b0;
        m_chg        = 1'b0;
        hist0.delete();
        hist1.delete();
        for (int k = 0; k < DL + 2; k++) begin
            hist0.push_back(1'b0);
            hist1.push_back(1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            m_deb[i] = 1'b0;
            m_rel[i] = 1'b0;
        end
    endfunction

    function automatic bit run_differs(input bit q[$], input bit d);
        bit r;
        r = 1'b1;
        for (int k = 0; k < DL; k++) begin
            if (q[q.size() - 2 - k] == d) r = 1'b0;
        end
        return r;
    endfunction

    function automatic void model_edge(input bit sw1, input bit sw2);
        int old_sel;
        bit r1;
        bit r2;
        bit f0;
        bit f1;
`ifdef BLINK_SELECT_AUTO_SCAN_EN
        bit tk;
`endif
        edge_n++;
        old_sel = m_sel;
        r1 = m_rel[0];
        r2 = m_rel[1];
`ifdef BLINK_SELECT_AUTO_SCAN_EN
        tk = m_auto && (((edge_n - restart_edge) % AP) == 0);
        if (r1 || tk) begin
            m_sel = (m_sel + 1) % 4;
            restart_edge = edge_n;
        end
        if (r2) begin
            m_auto = !m_auto;
            restart_edge = edge_n;
        end
`else
        if (r1 && !r2) m_sel = (m_sel + 1) % 4;
        else if (r2 && !r1) m_sel = (m_sel + 3) % 4;
`endif
        m_chg = (m_sel != old_sel);
        f0 = run_differs(hist0, m_deb[0]);
        f1 = run_differs(hist1, m_deb[1]);
        m_rel[0] = f0 && m_deb[0];
        m_rel[1] = f1 && m_deb[1];
        if (f0) m_deb[0] = !m_deb[0];
        if (f1) m_deb[1] = !m_deb[1];
        hist0.push_back(sw1);
        hist1.push_back(sw2);
        if (hist0.size() > DL + 2) void'(hist0.pop_front());
        if (hist1.size() > DL + 2) void'(hist1.pop_front());
    endfunction

    task automatic clk_step();
        @(posedge i_Clk);
        if (i_Rst_L) model_edge(bus.i_Switch_1, bus.i_Switch_2);
        #1;
    endtask

    task automatic do_reset();
        bus.i_Switch_1 = 1'b0;
        bus.i_Switch_2 = 1'b0;
        i_Rst_L = 1'b0;
        model_reset();
        repeat (2) clk_step();
        i_Rst_L = 1'b1;
    endtask

    task automatic test_reset();
        bus.i_Switch_1 = 1'b0;
        bus.i_Switch_2 = 1'b0;
        model_reset();
        #1 i_Rst_L = 1'b0;
        #1;
        checks++;
        if (bus.o_Sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", bus.o_Sel); end
        checks++;
        if (bus.o_Auto !== 1'b0) begin errors++; $display("FAIL reset_auto: got %0b expected 0", bus.o_Auto); end
        checks++;
        if (bus.o_Change !== 1'b0) begin errors++; $display("FAIL reset_change: got %0b expected 0", bus.o_Change); end
        repeat (2) clk_step();
        i_Rst_L = 1'b1;
        repeat (5) clk_step();
        checks++;
        if (bus.o_Sel !== 2'd0 || bus.o_Change !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got sel=%0d chg=%0b expected sel=0 chg=0", bus.o_Sel, bus.o_Change);
        end
    endtask

    task automatic test_switch1_steps();
        int hit;
        int pulses;
        for (int s = 1; s <= 4; s++) begin
            bus.i_Switch_1 = 1'b1;
            repeat (10) clk_step();
            bus.i_Switch_1 = 1'b0;
            hit = 0;
            pulses = 0;
            for (int k = 1; k <= 12; k++) begin
                clk_step();
                if (bus.o_Change === 1'b1) begin
                    pulses++;
                    if (hit == 0) hit = k;
                end
            end
            checks++;
            if (hit != 7) begin errors++; $display("FAIL step%0d_latency: got %0d expected 7", s, hit); end
            checks++;
            if (pulses != 1) begin errors++; $display("FAIL step%0d_pulses: got %0d expected 1", s, pulses); end
            checks++;
            if (bus.o_Sel !== 2'(s % 4)) begin errors++; $display("FAIL step%0d_sel: got %0d expected %0d", s, bus.o_Sel, s % 4); end
        end
    endtask

    task automatic test_bounce();
        int seen;
        bus.i_Switch_1 = 1'b1;
        repeat (10) clk_step();
        for (int len = 1; len <= 3; len++) begin
            seen = 0;
            bus.i_Switch_1 = 1'b0;
            repeat (len) begin
                clk_step();
                if (bus.o_Change === 1'b1) seen++;
            end
            bus.i_Switch_1 = 1'b1;
            repeat (10) begin
                clk_step();
                if (bus.o_Change === 1'b1) seen++;
            end
            checks++;
            if (seen != 0) begin errors++; $display("FAIL bounce%0d_change: got %0d pulses expected 0", len, seen); end
            checks++;
            if (bus.o_Sel !== 2'd0) begin errors++; $display("FAIL bounce%0d_sel: got %0d expected 0", len, bus.o_Sel); end
        end
        bus.i_Switch_1 = 1'b0;
        repeat (10) clk_step();
        checks++;
        if (bus.o_Sel !== 2'd1) begin errors++; $display("FAIL bounce_stable_release: got %0d expected 1", bus.o_Sel); end
    endtask

`ifdef BLINK_SELECT_AUTO_SCAN_EN
    task automatic wait_auto_rise(output int k_rise);
        k_rise = 0;
        for (int k = 1; k <= 20 && k_rise == 0; k++) begin
            clk_step();
            if (bus.o_Auto === 1'b1) k_rise = k;
        end
    endtask

    task automatic test_auto();
        int k_rise;
        int extra;
        int exp_sel;
        do_reset();
        bus.i_Switch_2 = 1'b1;
        repeat (10) clk_step();
        bus.i_Switch_2 = 1'b0;
        wait_auto_rise(k_rise);
        checks++;
        if (k_rise != 7) begin errors++; $display("FAIL auto_enter: got edge %0d expected 7", k_rise); end
        extra = 0;
        for (int t = 1; t <= 100; t++) begin
            if (t == 1)  bus.i_Switch_1 = 1'b1;
            if (t == 31) bus.i_Switch_1 = 1'b0;
            if (t == 40) bus.i_Switch_2 = 1'b1;
            if (t == 55) bus.i_Switch_2 = 1'b0;
            clk_step();
            if (t == 16 || t == 32 || t == 37 || t == 53) begin
                exp_sel = (t == 16) ? 1 : (t == 32) ? 2 : (t == 37) ? 3 : 0;
                checks++;
                if (bus.o_Change !== 1'b1 || bus.o_Sel !== 2'(exp_sel)) begin
                    errors++;
                    $display("FAIL auto_step_t%0d: got sel=%0d chg=%0b expected sel=%0d chg=1", t, bus.o_Sel, bus.o_Change, exp_sel);
                end
            end else if (bus.o_Change !== 1'b0) begin
                extra++;
            end
            if (t == 60 || t == 61) begin
                checks++;
                if (bus.o_Auto !== (t == 60)) begin
                    errors++; $display("FAIL auto_exit_t%0d: got %0b expected %0b", t, bus.o_Auto, (t == 60));
                end
            end
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL auto_spurious_change: got %0d expected 0", extra); end
        checks++;
        if (bus.o_Sel !== 2'd0) begin errors++; $display("FAIL auto_freeze: got %0d expected 0", bus.o_Sel); end
    endtask

    task automatic test_coincident();
        int k_rise;
        int extra;
        bus.i_Switch_1 = 1'b1;
        bus.i_Switch_2 = 1'b1;
        repeat (10) clk_step();
        bus.i_Switch_2 = 1'b0;
        wait_auto_rise(k_rise);
        checks++;
        if (k_rise != 7) begin errors++; $display("FAIL coinc_enter: got edge %0d expected 7", k_rise); end
        extra = 0;
        for (int t = 1; t <= 40; t++) begin
            if (t == 10) bus.i_Switch_1 = 1'b0;
            clk_step();
            if (t == 16 || t == 32) begin
                checks++;
                if (bus.o_Change !== 1'b1 || bus.o_Sel !== 2'(t / 16)) begin
                    errors++;
                    $display("FAIL coinc_t%0d: got sel=%0d chg=%0b expected sel=%0d chg=1", t, bus.o_Sel, bus.o_Change, t / 16);
                end
            end else if (bus.o_Change !== 1'b0) begin
                extra++;
            end
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL coinc_spurious_change: got %0d expected 0", extra); end
    endtask
`else
    task automatic test_backward();
        int pulses;
        do_reset();
        bus.i_Switch_2 = 1'b1;
        repeat (10) clk_step();
        bus.i_Switch_2 = 1'b0;
        pulses = 0;
        repeat (12) begin
            clk_step();
            if (bus.o_Change === 1'b1) pulses++;
        end
        checks++;
        if (bus.o_Sel !== 2'd3) begin errors++; $display("FAIL back_wrap: got %0d expected 3", bus.o_Sel); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL back_pulses: got %0d expected 1", pulses); end
        bus.i_Switch_1 = 1'b1;
        bus.i_Switch_2 = 1'b1;
        repeat (10) clk_step();
        bus.i_Switch_1 = 1'b0;
        bus.i_Switch_2 = 1'b0;
        pulses = 0;
        repeat (14) begin
            clk_step();
            if (bus.o_Change === 1'b1) pulses++;
        end
        checks++;
        if (bus.o_Sel !== 2'd3) begin errors++; $display("FAIL both_cancel_sel: got %0d expected 3", bus.o_Sel); end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL both_cancel_change: got %0d expected 0", pulses); end
    endtask
`endif

    task automatic test_reset_mid();
        int pulses;
        do_reset();
`ifdef BLINK_SELECT_AUTO_SCAN_EN
        bus.i_Switch_2 = 1'b1;
        repeat (10) clk_step();
        bus.i_Switch_2 = 1'b0;
        repeat (39) clk_step();
        bus.i_Switch_1 = 1'b1;
        repeat (3) clk_step();
        checks++;
        if (bus.o_Sel !== 2'd2 || bus.o_Auto !== 1'b1) begin
            errors++; $display("FAIL mid_setup: got sel=%0d auto=%0b expected sel=2 auto=1", bus.o_Sel, bus.o_Auto);
        end
`else
        repeat (2) begin
            bus.i_Switch_1 = 1'b1;
            repeat (10) clk_step();
            bus.i_Switch_1 = 1'b0;
            repeat (12) clk_step();
        end
        bus.i_Switch_1 = 1'b1;
        repeat (4) clk_step();
        checks++;
        if (bus.o_Sel !== 2'd2) begin errors++; $display("FAIL mid_setup: got sel=%0d expected 2", bus.o_Sel); end
`endif
        #2 i_Rst_L = 1'b0;
        #1;
        checks++;
        if (bus.o_Sel !== 2'd0 || bus.o_Auto !== 1'b0 || bus.o_Change !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: got sel=%0d auto=%0b chg=%0b expected all 0", bus.o_Sel, bus.o_Auto, bus.o_Change);
        end
        model_reset();
        repeat (2) clk_step();
        i_Rst_L = 1'b1;
        pulses = 0;
        repeat (20) begin
            clk_step();
            if (bus.o_Change === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.o_Sel !== 2'd0) begin
            errors++; $display("FAIL mid_no_spurious: got pulses=%0d sel=%0d expected 0 and 0", pulses, bus.o_Sel);
        end
        bus.i_Switch_1 = 1'b0;
        repeat (10) clk_step();
        checks++;
        if (bus.o_Sel !== 2'd1) begin errors++; $display("FAIL held_through_reset_release: got %0d expected 1", bus.o_Sel); end
    endtask

    task automatic test_random();
        int len1;
        int len2;
        len1 = 0;
        len2 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (len1 == 0) begin
                bus.i_Switch_1 = ~bus.i_Switch_1;
                len1 = $urandom_range(1, 12);
            end
            if (len2 == 0) begin
                bus.i_Switch_2 = ~bus.i_Switch_2;
                len2 = $urandom_range(1, 12);
            end
            len1--;
            len2--;
            clk_step();
            checks++;
            if (bus.o_Sel !== 2'(m_sel)) begin
                errors++; $display("FAIL rand_sel c=%0d: got %0d expected %0d", c, bus.o_Sel, m_sel);
            end
            checks++;
            if (bus.o_Auto !== m_auto) begin
                errors++; $display("FAIL rand_auto c=%0d: got %0b expected %0b", c, bus.o_Auto, m_auto);
            end
            checks++;
            if (bus.o_Change !== m_chg) begin
                errors++; $display("FAIL rand_change c=%0d: got %0b expected %0b", c, bus.o_Change, m_chg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_switch1_steps();
        test_bounce();
`ifdef BLINK_SELECT_AUTO_SCAN_EN
        test_auto();
        test_coincident();
`else
        test_backward();
`endif
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
